// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// rr_pick searches req upward from start with wrap-around and returns {found, idx}.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, GRANT} state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Walking the offsets downward leaves the smallest offset from start as the final winner.
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] cand;
    rr_pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = start + SEL_W'(k);
      if (req[cand]) rr_pick = {1'b1, cand};
    end
  endfunction

endpackage

// File: rtl/rr_sel_arbiter_if.sv
// Requester-side bundle of the select arbiter: requests/done in, select/grant/status out.
interface rr_sel_arbiter_if import mux_arb_pkg::*; #(
  parameter int CNT_W = 3
);
  logic [N_REQ-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic [CNT_W-1:0] dwell_cnt;

  modport master (output req, done, input sel, grant, busy, dwell_cnt);
  modport slave  (input req, done, output sel, grant, busy, dwell_cnt);
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational wrap-around first-one finder starting at index start.
module rr_priority_pick import mux_arb_pkg::*; (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  assign {found, idx} = rr_pick(req, start);
endmodule

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select; grants are held until done, withdrawal or dwell timeout.
// All outputs are registered: req sampled at one edge shows up as a grant right after that edge.
module rr_sel_arbiter import mux_arb_pkg::*; #(
  parameter int DWELL = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk_n,
  input  logic             reset_n,
  rr_sel_arbiter_if.slave  bus
);
  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [SEL_W-1:0] last_ptr, last_nxt;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic             busy_q, busy_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic [N_REQ-1:0] pick_req;
  logic [SEL_W-1:0] pick_start;
  logic             found;
  logic [SEL_W-1:0] winner;
  logic             rel;

  // While granting, the current owner is masked so a back-to-back grant always moves on.
  assign pick_req   = (state == GRANT) ? (bus.req & ~onehot(sel_q)) : bus.req;
  assign pick_start = (state == GRANT) ? sel_q + SEL_W'(1) : last_ptr + SEL_W'(1);
  assign rel        = bus.done | ~bus.req[sel_q] | (cnt_q == CNT_W'(DWELL - 1));

  rr_priority_pick u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (found),
    .idx   (winner)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    last_nxt  = last_ptr;
    grant_nxt = grant_q;
    busy_nxt  = busy_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          last_nxt  = winner;
          grant_nxt = onehot(winner);
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!rel) begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end else if (found) begin
          sel_nxt   = winner;
          last_nxt  = winner;
          grant_nxt = onehot(winner);
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_ptr starts at the top index so input 0 wins the first arbitration.
  always_ff @(posedge clk_n or posedge reset_n) begin
    if (reset_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      last_ptr <= SEL_W'(N_REQ - 1);
      grant_q  <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      last_ptr <= last_nxt;
      grant_q  <= grant_nxt;
      busy_q   <= busy_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;
  assign bus.dwell_cnt = cnt_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus random traffic against a cycle-level model.
module tb_rr_sel_arbiter;
  localparam int DWELL = 8;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  rr_sel_arbiter_if #(.CNT_W(3)) bus ();

  rr_sel_arbiter #(.DWELL(DWELL), .CNT_W(3)) dut (
    .clk_n   (clk),
    .reset_n (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {sel, grant, busy, dwell_cnt}.
  logic [9:0] dut_out;
  logic [9:0] exp;
  assign dut_out = {bus.sel, bus.grant, bus.busy, bus.dwell_cnt};

  // Reference model: owner index, busy flag, elapsed cycles, last granted index.
  bit m_busy;
  int m_owner, m_cnt, m_last;

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_last = 3;
  endtask

  function automatic int rr_search(input logic [3:0] r, input int after);
    for (int off = 1; off <= 4; off++)
      if (r[(after + off) % 4]) return (after + off) % 4;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic d);
    int w;
    logic [3:0] others;
    if (!m_busy) begin
      w = rr_search(r, m_last);
      if (w >= 0) begin m_busy = 1'b1; m_owner = w; m_last = w; m_cnt = 0; end
    end else if (d || !r[m_owner] || m_cnt == DWELL - 1) begin
      others = r;
      others[m_owner] = 1'b0;
      w = rr_search(others, m_owner);
      if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 0; end
      else begin m_busy = 1'b0; m_cnt = 0; end
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [9:0] model_out();
    logic [3:0] g;
    g = m_busy ? 4'(1 << m_owner) : 4'b0000;
    return {2'(m_owner), g, m_busy, 3'(m_cnt)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(bus.req, bus.done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (dut_out !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_async: got %b required %b", dut_out, 10'b0);
    end
    @(negedge clk);
    tests_run++;
    if (dut_out !== 10'b0) begin
      tests_failed++;
      $display("FAIL reset_held_edge: got %b required %b", dut_out, 10'b0);
    end
    rst = 1'b0;
    model_reset();
    step();
    exp = {2'd0, 4'b0001, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got %b required %b", dut_out, exp);
    end
  endtask

  task automatic test_rotation();
    for (int i = 1; i <= 4; i++) begin
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      exp = {2'(i % 4), 4'(1 << (i % 4)), 1'b1, 3'd0};
      tests_run++;
      if (dut_out !== exp) begin
        tests_failed++;
        $display("FAIL rotation_%0d: got %b required %b", i, dut_out, exp);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0100;
    for (int c = 0; c < DWELL; c++) begin
      step();
      exp = {2'd2, 4'b0100, 1'b1, 3'(c)};
      tests_run++;
      if (dut_out !== exp) begin
        tests_failed++;
        $display("FAIL timeout_cnt%0d: got %b required %b", c, dut_out, exp);
      end
    end
    step();
    exp = {2'd2, 4'b0000, 1'b0, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL timeout_bubble: got %b required %b", dut_out, exp);
    end
    step();
    exp = {2'd2, 4'b0100, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL timeout_regrant: got %b required %b", dut_out, exp);
    end
  endtask

  task automatic test_withdrawal();
    do_reset();
    bus.req = 4'b1010;
    step();
    step();
    exp = {2'd1, 4'b0010, 1'b1, 3'd1};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL withdraw_owner: got %b required %b", dut_out, exp);
    end
    bus.req = 4'b1000;
    step();
    exp = {2'd3, 4'b1000, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL withdraw_handover: got %b required %b", dut_out, exp);
    end
  endtask

  task automatic test_skip_wrap();
    do_reset();
    bus.req = 4'b0110;
    step();
    exp = {2'd1, 4'b0010, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL skip_first: got %b required %b", dut_out, exp);
    end
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    exp = {2'd2, 4'b0100, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL skip_second: got %b required %b", dut_out, exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b0001;
    for (int i = 0; i < 6; i++) step();
    exp = {2'd0, 4'b0001, 1'b1, 3'd5};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL areset_pre: got %b required %b", dut_out, exp);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if (dut_out !== 10'b0) begin
      tests_failed++;
      $display("FAIL areset_immediate: got %b required %b", dut_out, 10'b0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req = 4'b1111;
    step();
    exp = {2'd0, 4'b0001, 1'b1, 3'd0};
    tests_run++;
    if (dut_out !== exp) begin
      tests_failed++;
      $display("FAIL areset_restart: got %b required %b", dut_out, exp);
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.req = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 3) == 0);
      step();
      exp = model_out();
      tests_run++;
      if (dut_out !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d: got %b required %b (req=%b)", i, dut_out, exp, bus.req);
      end
    end
    bus.done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.done = 1'b0;
    model_reset();
    test_reset();
    test_rotation();
    test_timeout();
    test_withdrawal();
    test_skip_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
